// File: rtl/innerproduct_pkg.sv
// innerproduct_pkg: shared state type and width helpers for the streaming inner-product MAC
package innerproduct_pkg;
    typedef enum logic {ACC, HOLD} state_t;

    function automatic int idx_w(input int nfeat);
        return nfeat > 0 ? $clog2(nfeat + 1) : 1;
    endfunction

    function automatic int ch_w(input int nch);
        return nch > 1 ? $clog2(nch) : 1;
    endfunction
endpackage

// File: rtl/innerproduct_mac_lane.sv
// mac_lane: one hidden unit -- weight register file, bias-init mux and multiply-accumulate
module mac_lane
    import innerproduct_pkg::*;
#(
    parameter int NFEAT      = 80,
    parameter int XW         = 7,
    parameter int TW         = 16,
    parameter int AW         = 32,
    parameter int BIAS_SHIFT = 16,
    parameter int IW         = idx_w(NFEAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [TW-1:0] wdata,
    input  logic          beat,
    input  logic          first,
    input  logic [IW-1:0] idx,
    input  logic [XW-1:0] x,
    output logic [AW-1:0] acc
);
    logic signed [TW-1:0] w_q [NFEAT+1];
    logic signed [TW-1:0] w_d [NFEAT+1];
    logic signed [AW-1:0] acc_q, acc_d, xs, ws, base;

    // both operands widened to AW so the truncated product is the product modulo 2^AW
    always_comb begin
        w_d = w_q;
        if (we) w_d[waddr] = wdata;
        xs = AW'($signed({1'b0, x}));
        ws = AW'(w_q[idx]);
        base = first ? AW'(w_q[0]) <<< BIAS_SHIFT : acc_q;
        acc_d = beat ? base + xs * ws : acc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            w_q <= '{default: '0};
        end else begin
            acc_q <= acc_d;
            w_q <= w_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/innerproduct_mac.sv
// innerproduct_mac: streaming NCH-lane dot product with bias, frame FSM and runtime weight loading
module innerproduct_mac
    import innerproduct_pkg::*;
#(
    parameter int NFEAT      = 80,
    parameter int NCH        = 1,
    parameter int XW         = 7,
    parameter int TW         = 16,
    parameter int AW         = 32,
    parameter int BIAS_SHIFT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XW-1:0]            in_x,
    input  logic                     w_we,
    output logic                     w_ready,
    input  logic [ch_w(NCH)-1:0]     w_ch,
    input  logic [idx_w(NFEAT)-1:0]  w_addr,
    input  logic [TW-1:0]            w_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCH*AW-1:0]        hidden,
    output logic                     err
);
    localparam int IW = idx_w(NFEAT);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          beat, last, wr_ok;

    always_comb begin
        beat = in_valid && state_q == ACC;
        last = idx_q == IW'(NFEAT);
        wr_ok = w_we && w_ready && int'(w_addr) <= NFEAT && int'(w_ch) < NCH;
        state_d = state_q == ACC ? (beat && last ? HOLD : ACC) : (out_ready ? ACC : HOLD);
        idx_d = beat ? (last ? IW'(1) : idx_q + IW'(1)) : idx_q;
        err_d = err_q | (w_we && !wr_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            idx_q <= IW'(1);
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign in_ready = state_q == ACC;
    assign w_ready = state_q == ACC && idx_q == IW'(1);
    assign out_valid = state_q == HOLD;
    assign err = err_q;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        mac_lane #(
            .NFEAT(NFEAT), .XW(XW), .TW(TW), .AW(AW), .BIAS_SHIFT(BIAS_SHIFT), .IW(IW)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .we(wr_ok && int'(w_ch) == c),
            .waddr(w_addr),
            .wdata(w_data),
            .beat(beat),
            .first(idx_q == IW'(1)),
            .idx(idx_q),
            .x(in_x),
            .acc(hidden[c*AW +: AW])
        );
    end
endmodule
